// File: rtl/row_smoother_if.sv
// Row stream from the smoother to the write-back stage: one smoothed row per
// valid/ready handshake.
interface row_smoother_if #(
  parameter int unsigned DATA_W = 1024,
  parameter int unsigned ROW_W  = 7
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [ROW_W-1:0]  row;

  modport master (
    output valid,
    output data,
    output row,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  row,
    output ready
  );
endinterface

// File: rtl/row_smoother.sv
// 3x3 box-mean row smoother: streams image rows from the input RAM through a
// 3-row window and emits one edge-clamped smoothed row per handshake.
module row_smoother #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned COLS   = 128,
  parameter int unsigned ROWS   = 128,
  parameter int unsigned ADDR_W = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic [ADDR_W-1:0]       in_ram_address,
  input  logic [COLS*PIX_W-1:0]   in_ram_data,
  row_smoother_if.master          out,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned ROW_W = COLS * PIX_W;
  localparam int unsigned SUM_W = PIX_W + 4;
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StCapture,
    StCalc,
    StHold,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] r_q, r_d;
  logic [ROW_W-1:0]  prev_q, prev_d;
  logic [ROW_W-1:0]  cur_q, cur_d;
  logic [ROW_W-1:0]  next_q, next_d;
  logic              fill_q, fill_d;
  logic              valid_q, valid_d;
  logic [ROW_W-1:0]  data_q, data_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ROW_W-1:0]  smooth;

  function automatic logic [SUM_W-1:0] px(input logic [ROW_W-1:0] line, input int unsigned idx);
    return SUM_W'(line[PIX_W*idx +: PIX_W]);
  endfunction

  // Border columns reuse their edge pixel in place of the missing neighbour.
  for (genvar j = 0; j < COLS; j++) begin : g_col
    localparam int unsigned JL = (j == 0) ? 0 : j - 1;
    localparam int unsigned JR = (j == COLS - 1) ? COLS - 1 : j + 1;
    logic [SUM_W-1:0] sum;
    assign sum = px(prev_q, JL) + px(prev_q, j) + px(prev_q, JR)
               + px(cur_q, JL)  + px(cur_q, j)  + px(cur_q, JR)
               + px(next_q, JL) + px(next_q, j) + px(next_q, JR);
    assign smooth[PIX_W*j +: PIX_W] = PIX_W'(sum / SUM_W'(9));
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    r_d     = r_q;
    prev_d  = prev_q;
    cur_d   = cur_q;
    next_d  = next_q;
    fill_d  = fill_q;
    valid_d = valid_q;
    data_d  = data_q;
    row_d   = row_q;
    busy_d  = busy_q;
    done_d  = done_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StFetch;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          r_d     = '0;
          addr_d  = '0;
          fill_d  = 1'b1;
        end
      end
      StFetch: state_d = StCapture;
      StCapture: begin
        if (fill_q) begin
          // First fetch of a frame: row 0 stands in for the missing row above.
          prev_d = in_ram_data;
          cur_d  = in_ram_data;
          fill_d = 1'b0;
          if (ROWS == 1) begin
            next_d  = in_ram_data;
            state_d = StCalc;
          end else begin
            addr_d  = ADDR_W'(1);
            state_d = StFetch;
          end
        end else begin
          next_d  = in_ram_data;
          state_d = StCalc;
        end
      end
      StCalc: begin
        data_d  = smooth;
        row_d   = r_q;
        valid_d = 1'b1;
        state_d = StHold;
      end
      StHold: begin
        if (out.ready) begin
          valid_d = 1'b0;
          if (r_q == LAST_ROW) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            prev_d = cur_q;
            cur_d  = next_q;
            r_d    = r_q + ADDR_W'(1);
            if (32'(r_q) + 32'd2 <= ROWS - 1) begin
              addr_d  = ADDR_W'(32'(r_q) + 32'd2);
              state_d = StFetch;
            end else begin
              // Bottom clamp: next_q already holds the last row, which is also the new cur.
              state_d = StCalc;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      r_q     <= '0;
      prev_q  <= '0;
      cur_q   <= '0;
      next_q  <= '0;
      fill_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      row_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      r_q     <= r_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
      next_q  <= next_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      row_q   <= row_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign in_ram_address = addr_q;
  assign out.valid      = valid_q;
  assign out.data       = data_q;
  assign out.row        = row_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
